sram_bus_master: RTL
====================

Name: sram_bus_master

Overview:
- Initiator for the 4-bit-data / 2-bit-address synchronous SRAM bus (addr, bidirectional data, we, oe).
- Takes single read/write requests on a valid/ready handshake and sequences the bus strobes.
- Drives write data, waits out the RAM's registered read latency, and returns read data on a one-cycle response pulse.
- The tristate is split into out/oe/in; the top level builds the inout pins.

Parameters:
- ADDR_W, 2, address width.
- DATA_W, 4, data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata is valid.
- rsp_rdata  out  DATA_W  read data.
- bus_addr  out  ADDR_W  SRAM address.
- bus_we  out  1  SRAM write enable.
- bus_oe  out  1  SRAM output enable.
- bus_data_out  out  DATA_W  data the master drives.
- bus_data_oe  out  1  master drives the data bus.
- bus_data_in  in  DATA_W  sampled data bus.
- verify_err  out  1  readback mismatch flag (only with the optional feature).

Behaviour:
- Reset values:
  - req_ready=0 during reset, 1 in IDLE afterwards.
  - rsp_valid=0, rsp_rdata=0.
  - bus_we=0, bus_oe=0, bus_data_oe=0, bus_addr=0, bus_data_out=0.
  - verify_err=0.
- Request acceptance:
  - FSM states: IDLE, WR, RD_ADDR, RD_DATA, TURN.
  - req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready.
  - Address, write flag and write data are latched on acceptance.
- IDLE:
  - Accepted write -> WR.
  - Accepted read -> RD_ADDR.
  - Otherwise stay in IDLE.
- WR (one cycle):
  - bus_we=1, bus_oe=0, bus_data_oe=1, bus_addr and bus_data_out = latched values.
  - The RAM writes at the end of this cycle. Next state IDLE.
- RD_ADDR (one cycle):
  - bus_oe=1, bus_we=0, bus_data_oe=0. The RAM registers mem[addr] at the end of the cycle. Next state RD_DATA.
- RD_DATA (one cycle):
  - bus_oe=1, same address. The RAM drives data.
  - bus_data_in is captured into rsp_rdata at the end of the cycle. Next state TURN.
- TURN (one cycle):
  - All strobes low, bus not driven. rsp_valid=1 for exactly this cycle. Next state IDLE.
  - TURN is the bus turnaround cycle; it prevents contention when a write follows a read.
- Latency, counted from the accept edge:
  - Read: rsp_valid is high in the 3rd cycle after accept. Reads complete every 4 cycles.
  - Write: a new request can be accepted 2 cycles after accept, so writes complete every 2 cycles.
- Invariants:
  - bus_data_oe && bus_oe never true together.
  - bus_we && bus_oe never true together.
  - bus_addr is stable for the whole of a read.
- rsp_rdata holds its value until the next read capture.
- Reset mid-operation:
  - The FSM returns to IDLE on the next edge.
  - All strobes and rsp_valid drop immediately (registered reset). The in-flight request is dropped and produces no response.
- Request inputs are ignored while req_ready=0; there is no queueing.

Optional Feature:
- Macro: SRAM_MASTER_VERIFY_EN.
- Defined:
  - Every write is followed automatically by a readback of the same address: WR -> RD_ADDR -> RD_DATA -> TURN, with rsp_valid suppressed for the readback.
  - If the sampled data differs from the written data, verify_err is set; it is sticky until rst.
  - Write throughput drops to one per 5 cycles.
- Undefined:
  - verify_err is tied to 0 and writes take the plain WR path.

Decomposition:
- Shared package sram_bus_pkg holds:
  - the FSM state enum;
  - ADDR_W and DATA_W defaults;
  - the read-latency constant RD_LAT=1 (RAM registers read data on the oe edge).
- No sub-module needed. The only optional split is sram_bus_tristate (out/oe/in to inout), which lives at the top level, not inside this block.

Test Plan:
- After reset with RAM contents {1,2,3,4}: read addr 2 -> rsp_valid high exactly 3 cycles after accept, rsp_rdata=0x3; bus_oe high for exactly 2 cycles.
- Write addr 1 = 0xA, then read addr 1 -> rsp_rdata=0xA; bus_we high 1 cycle with bus_data_oe=1 and bus_data_out=0xA.
- req_valid held high with alternating read/write requests -> req_ready low outside IDLE; no request lost or duplicated; bus_data_oe && bus_oe never both high; TURN idle cycle present after every read.
- Assert rst during RD_DATA -> next cycle all strobes 0, rsp_valid 0, req_ready 1 after reset deasserts, no response emitted.
- SRAM_MASTER_VERIFY_EN with a fault model forcing bit 0 of addr 3 to 0: write 0x5 to addr 3 -> verify_err=1 (sticky); no rsp_valid for the readback.
- SRAM_MASTER_VERIFY_EN with a clean RAM: write 0xF to addr 0 -> verify_err stays 0; next request accepted 5 cycles after the write accept.

Source files
------------

// File: rtl/sram_bus_pkg.sv
`default_nettype none
//==============================================================================
// Package  : sram_bus_pkg
// Purpose  : Shared types and defaults for the 4-bit/2-bit SRAM bus master.
// Revision : 1.0  initial release
//==============================================================================
package sram_bus_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 4;

  // The RAM registers read data on the edge that ends the oe/address cycle.
  localparam int RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_TURN    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sram_bus_master.sv
`default_nettype none
//==============================================================================
// Module   : sram_bus_master
// Purpose  : Single-request initiator for a synchronous SRAM bus (we/oe strobes,
//            split tristate data). Option SRAM_MASTER_VERIFY_EN adds a
//            readback check after every write, flagged on verify_err.
// Revision : 1.0  initial release
//==============================================================================
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic              bus_oe,
  output logic [DATA_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic              verify_err
);

  state_e              state_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [ADDR_W-1:0]   bus_addr_q;
  logic                bus_we_q;
  logic                bus_oe_q;
  logic [DATA_W-1:0]   bus_data_out_q;
  logic                bus_data_oe_q;

  assign req_ready    = (state_q == ST_IDLE) && !rst;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign bus_addr     = bus_addr_q;
  assign bus_we       = bus_we_q;
  assign bus_oe       = bus_oe_q;
  assign bus_data_out = bus_data_out_q;
  assign bus_data_oe  = bus_data_oe_q;

`ifdef SRAM_MASTER_VERIFY_EN
  logic verify_q;
  logic verify_err_q;
  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

  // Outputs are registered alongside the state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      bus_addr_q     <= '0;
      bus_we_q       <= 1'b0;
      bus_oe_q       <= 1'b0;
      bus_data_out_q <= '0;
      bus_data_oe_q  <= 1'b0;
`ifdef SRAM_MASTER_VERIFY_EN
      verify_q       <= 1'b0;
      verify_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            bus_addr_q <= req_addr;
            if (req_write) begin
              state_q        <= ST_WR;
              bus_we_q       <= 1'b1;
              bus_data_oe_q  <= 1'b1;
              bus_data_out_q <= req_wdata;
            end else begin
              state_q  <= ST_RD_ADDR;
              bus_oe_q <= 1'b1;
            end
          end
        end
        ST_WR: begin
          bus_we_q      <= 1'b0;
          bus_data_oe_q <= 1'b0;
`ifdef SRAM_MASTER_VERIFY_EN
          state_q  <= ST_RD_ADDR;
          bus_oe_q <= 1'b1;
          verify_q <= 1'b1;
`else
          state_q  <= ST_IDLE;
`endif
        end
        ST_RD_ADDR: begin
          state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          state_q  <= ST_TURN;
          bus_oe_q <= 1'b0;
`ifdef SRAM_MASTER_VERIFY_EN
          if (verify_q) begin
            // bus_data_out_q still holds the data of the write being checked.
            if (bus_data_in != bus_data_out_q) begin
              verify_err_q <= 1'b1;
            end
          end else begin
            rsp_rdata_q <= bus_data_in;
            rsp_valid_q <= 1'b1;
          end
`else
          rsp_rdata_q <= bus_data_in;
          rsp_valid_q <= 1'b1;
`endif
        end
        ST_TURN: begin
          state_q <= ST_IDLE;
`ifdef SRAM_MASTER_VERIFY_EN
          verify_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
